uart_rx: RTL

Standalone UART receiver that recovers serial frames (1 start bit, INPUT_DATA_WIDTH data bits sent LSB first, optional parity bit, 1 stop bit) using an oversampled bit clock. It re-times the asynchronous `serial_in` line through a flip-flop synchronizer chain, checks parity and framing, and presents each received word with a single-cycle valid strobe. It is the receive-side counterpart to the UART transmitter and uses the same frame format and parity convention, so a transmitter's `serial_out` can drive it directly.

---
 rtl/uart_rx_if.sv | 21 ++
 rtl/uart_rx.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line plus received-word signals of the UART receiver.
// slave = the receiver itself, master = the side driving the line and consuming words.
interface uart_rx_if #(
  parameter int INPUT_DATA_WIDTH = 8
);
  logic                        serial_in;
  logic [INPUT_DATA_WIDTH-1:0] received_data;
  logic                        data_is_valid;
  logic                        rx_error;
  logic                        o_busy;

  modport master (
    output serial_in,
    input  received_data, data_is_valid, rx_error, o_busy
  );

  modport slave (
    input  serial_in,
    output received_data, data_is_valid, rx_error, o_busy
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver (start, data LSB first, optional parity, stop).
// Optional build macro UART_RX_MAJORITY_VOTE_EN: every bit decision becomes the
// 2-of-3 majority of the line at ticks mid-1, mid, mid+1, taken one tick later.
module uart_rx #(
  parameter int INPUT_DATA_WIDTH           = 8,
  parameter int PARITY_ENABLED             = 1,
  parameter int PARITY_TYPE                = 0,
  parameter int CLOCKS_PER_BIT             = 8,
  parameter int SAMPLE_DIV                 = 1,
  parameter int NUMBER_OF_RX_SYNCHRONIZERS = 3
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.slave rx_if
);
  localparam int W  = INPUT_DATA_WIDTH;
  localparam int NS = NUMBER_OF_RX_SYNCHRONIZERS;
  localparam int TW = $clog2(CLOCKS_PER_BIT + 1);
  localparam int DW = $clog2(SAMPLE_DIV + 1);
  localparam int BW = $clog2(W + 1);
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int VOTE_DLY = 1;
`else
  localparam int VOTE_DLY = 0;
`endif
  // Start bit is decided half a bit in; every later bit one full bit after the previous.
  localparam logic [TW-1:0] START_TICK = TW'(CLOCKS_PER_BIT / 2 - 1 + VOTE_DLY);
  localparam logic [TW-1:0] BIT_TICK   = TW'(CLOCKS_PER_BIT - 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(SAMPLE_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT   = BW'(W - 1);

  typedef enum logic [2:0] {IDLE, START_BIT, DATA_BIT, PARITY_BIT, STOP_BIT} state_e;

  state_e          state_q, state_d;
  logic [NS-1:0]   sync_q;
  logic            rx_s, rx_prev_q, fall_q;
  logic [DW-1:0]   div_q, div_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [W-1:0]    shift_q, shift_d, data_q, data_d;
  logic [W:0]      shift_cat;
  logic            par_err_q, par_err_d;
  logic            valid_q, valid_d, err_q, err_d, busy_q, busy_d;
  logic            tick_en, sample, exp_par;

  assign rx_s      = sync_q[NS-1];
  assign tick_en   = (div_q == DIV_LAST);
  assign shift_cat = {sample, shift_q};
  assign exp_par   = (PARITY_TYPE == 0) ? ^shift_q : ~^shift_q;

  // Re-time the async line and register its falling edge (idle level is 1).
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
      fall_q    <= 1'b0;
    end else begin
      sync_q[0] <= rx_if.serial_in;
      for (int i = 1; i < NS; i++) sync_q[i] <= sync_q[i-1];
      rx_prev_q <= rx_s;
      fall_q    <= rx_prev_q & ~rx_s;
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] hist_q;
  // Keep the two previous tick samples so the vote covers mid-1, mid, mid+1.
  always_ff @(posedge clk) begin
    if (reset)                          hist_q <= '1;
    else if (state_q != IDLE && tick_en) hist_q <= {hist_q[0], rx_s};
  end
  assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
  assign sample = rx_s;
`endif

  // Frame state machine: tick pacing, bit decisions, result strobe.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    busy_d    = busy_q;
    if (state_q != IDLE) begin
      div_d = tick_en ? '0 : div_q + 1'b1;
      if (tick_en) tick_d = tick_q + 1'b1;
    end
    case (state_q)
      IDLE: if (fall_q) begin
        state_d   = START_BIT;
        busy_d    = 1'b1;
        div_d     = '0;
        tick_d    = '0;
        par_err_d = 1'b0;
      end
      START_BIT: if (tick_en && tick_q == START_TICK) begin
        tick_d = '0;
        bit_d  = '0;
        if (sample) begin
          state_d = IDLE;          // line bounced back high: false start
          busy_d  = 1'b0;
        end else begin
          state_d = DATA_BIT;
        end
      end
      DATA_BIT: if (tick_en && tick_q == BIT_TICK) begin
        tick_d  = '0;
        shift_d = shift_cat[W:1];
        bit_d   = bit_q + 1'b1;
        if (bit_q == LAST_BIT) state_d = (PARITY_ENABLED != 0) ? PARITY_BIT : STOP_BIT;
      end
      PARITY_BIT: if (tick_en && tick_q == BIT_TICK) begin
        tick_d    = '0;
        par_err_d = (sample != exp_par);
        state_d   = STOP_BIT;
      end
      STOP_BIT: if (tick_en && tick_q == BIT_TICK) begin
        tick_d  = '0;
        state_d = IDLE;
        valid_d = 1'b1;
        data_d  = shift_q;
        err_d   = par_err_q | ~sample;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      div_q     <= '0;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign rx_if.received_data = data_q;
  assign rx_if.data_is_valid = valid_q;
  assign rx_if.rx_error      = err_q;
  assign rx_if.o_busy        = busy_q;
endmodule
